// File: rtl/branch_pc_unit.sv
// branch_pc_unit: PC sequencer with branch resolution, direct-mapped BTB prediction,
// one-cycle mispredict redirect/flush and saturating branch statistics.
module branch_pc_unit #(
  parameter int              WIDTH       = 32,
  parameter logic [WIDTH-1:0] RESET_PC   = '0,
  parameter int              INSTR_BYTES = 4,
  parameter int              BTB_IDX     = 4,
  parameter int              CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall_i,
  output logic [WIDTH-1:0] pc_o,
  output logic             pred_taken_o,
  input  logic             br_valid_i,
  input  logic [WIDTH-1:0] br_pc_i,
  input  logic [2:0]       br_mode_i,
  input  logic [WIDTH-1:0] br_a_i,
  input  logic [WIDTH-1:0] br_b_i,
  input  logic [WIDTH-1:0] br_target_i,
  input  logic             br_pred_i,
  output logic             flush_o,
  output logic [CNT_W-1:0] branch_cnt_o,
  output logic [CNT_W-1:0] mispred_cnt_o
);
  localparam int N  = 1 << BTB_IDX;
  localparam int TW = WIDTH - BTB_IDX - 2;

  logic [WIDTH-1:0] pc_q, pc_d;
  logic             flush_q;
  logic [CNT_W-1:0] bcnt_q, mcnt_q;
  logic             v_q   [N];
  logic [TW-1:0]    tag_q [N];
  logic [WIDTH-1:0] tgt_q [N];
  logic [1:0]       ctr_q [N];

  logic [BTB_IDX-1:0] f_idx, b_idx;
  logic               f_hit, b_hit, eq, lt_s, lt_u, taken, mispred;
  logic [WIDTH-1:0]   pred_next, actual_next;
  logic [1:0]         ctr_nx;

  always_comb begin
    f_idx        = pc_q[BTB_IDX+1:2];
    f_hit        = v_q[f_idx] && tag_q[f_idx] == pc_q[WIDTH-1:BTB_IDX+2];
    pred_taken_o = f_hit && ctr_q[f_idx][1];
    pred_next    = pred_taken_o ? tgt_q[f_idx] : pc_q + WIDTH'(INSTR_BYTES);
    b_idx        = br_pc_i[BTB_IDX+1:2];
    b_hit        = v_q[b_idx] && tag_q[b_idx] == br_pc_i[WIDTH-1:BTB_IDX+2];
    eq           = br_a_i == br_b_i;
    lt_s         = $signed(br_a_i) < $signed(br_b_i);
    lt_u         = br_a_i < br_b_i;
    taken        = br_mode_i == 3'd0 ? eq   :
                   br_mode_i == 3'd1 ? !eq  :
                   br_mode_i == 3'd2 ? lt_s :
                   br_mode_i == 3'd3 ? !lt_s :
                   br_mode_i == 3'd4 ? lt_u :
                   br_mode_i == 3'd5 ? !lt_u :
                   br_mode_i == 3'd6;
    // a correctly predicted taken branch still redirects wrongly if the BTB target is stale
    mispred      = br_valid_i && (taken != br_pred_i ||
                   (taken && br_pred_i && !(b_hit && tgt_q[b_idx] == br_target_i)));
    actual_next  = taken ? br_target_i : br_pc_i + WIDTH'(INSTR_BYTES);
    pc_d         = mispred ? actual_next : stall_i ? pc_q : pred_next;
    ctr_nx       = taken ? (ctr_q[b_idx] == 2'b11 ? 2'b11 : ctr_q[b_idx] + 2'b01)
                         : (ctr_q[b_idx] == 2'b00 ? 2'b00 : ctr_q[b_idx] - 2'b01);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= RESET_PC;
      flush_q <= 1'b0;
      bcnt_q  <= '0;
      mcnt_q  <= '0;
      for (int i = 0; i < N; i++) begin
        v_q[i]   <= 1'b0;
        tag_q[i] <= '0;
        tgt_q[i] <= '0;
        ctr_q[i] <= 2'b01;
      end
    end else begin
      pc_q    <= pc_d;
      flush_q <= mispred;
      if (br_valid_i) begin
        if (!(&bcnt_q)) bcnt_q <= bcnt_q + 1'b1;
        if (mispred && !(&mcnt_q)) mcnt_q <= mcnt_q + 1'b1;
        if (b_hit) ctr_q[b_idx] <= ctr_nx;
        if (taken) begin
          v_q[b_idx]   <= 1'b1;
          tag_q[b_idx] <= br_pc_i[WIDTH-1:BTB_IDX+2];
          tgt_q[b_idx] <= br_target_i;
          if (!b_hit) ctr_q[b_idx] <= 2'b10;
        end
      end
    end
  end

  assign pc_o          = pc_q;
  assign flush_o       = flush_q;
  assign branch_cnt_o  = bcnt_q;
  assign mispred_cnt_o = mcnt_q;
endmodule

// File: tb/tb_branch_pc_unit.sv
// tb_branch_pc_unit: randomized + directed stimulus against a behavioural PC/BTB model,
// expected per-cycle state queued by the driver and compared by an independent monitor.
module tb_branch_pc_unit;
  localparam int CW   = 6;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 0, rst_n = 0, stall = 0, br_valid = 0, br_pred = 0;
  logic [31:0]   br_pc = 0, br_a = 0, br_b = 0, br_target = 0;
  logic [2:0]    br_mode = 0;
  logic [31:0]   pc;
  logic          pred_taken, flush;
  logic [CW-1:0] branch_cnt, mispred_cnt;

  branch_pc_unit #(.WIDTH(32), .RESET_PC(32'h0), .INSTR_BYTES(4), .BTB_IDX(4), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .stall_i(stall), .pc_o(pc), .pred_taken_o(pred_taken),
    .br_valid_i(br_valid), .br_pc_i(br_pc), .br_mode_i(br_mode), .br_a_i(br_a), .br_b_i(br_b),
    .br_target_i(br_target), .br_pred_i(br_pred), .flush_o(flush),
    .branch_cnt_o(branch_cnt), .mispred_cnt_o(mispred_cnt));

  always #5 clk = ~clk;

  typedef struct { logic [31:0] pc; bit fl; int bc; int mc; bit pt; } exp_t;
  exp_t q[$];
  int vectors = 0, miscompares = 0;

  bit          m_v[16];
  logic [31:0] m_tag[16], m_tgt[16];
  int          m_ctr[16];
  logic [31:0] m_pc;
  int          m_bc, m_mc;

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin m_v[i] = 0; m_ctr[i] = 1; m_tag[i] = 0; m_tgt[i] = 0; end
    m_pc = 0; m_bc = 0; m_mc = 0;
  endtask

  function automatic bit m_hit(logic [31:0] a);
    return m_v[a[5:2]] && m_tag[a[5:2]] == (a >> 6);
  endfunction

  function automatic bit m_pred(logic [31:0] a);
    return m_hit(a) && m_ctr[a[5:2]] >= 2;
  endfunction

  function automatic bit m_taken(logic [2:0] md, logic [31:0] a, logic [31:0] b);
    case (md)
      3'd0: return a == b;
      3'd1: return a != b;
      3'd2: return $signed(a) < $signed(b);
      3'd3: return $signed(a) >= $signed(b);
      3'd4: return a < b;
      3'd5: return a >= b;
      3'd6: return 1;
      default: return 0;
    endcase
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  // drive one cycle of inputs, advance the model, queue the state expected after the edge
  task automatic step(bit st, bit bv, logic [31:0] bpc, logic [2:0] md,
                      logic [31:0] a, logic [31:0] b, logic [31:0] t, bit bp);
    bit tk, mis, hit;
    int ix;
    logic [31:0] nxt;
    exp_t e;
    stall = st; br_valid = bv; br_pc = bpc; br_mode = md; br_a = a; br_b = b;
    br_target = t; br_pred = bp;
    tk = m_taken(md, a, b);
    ix = int'(bpc[5:2]);
    hit = m_hit(bpc);
    mis = bv && ((tk != bp) || (tk && bp && !(hit && m_tgt[ix] == t)));
    nxt = m_pred(m_pc) ? m_tgt[m_pc[5:2]] : m_pc + 4;
    m_pc = mis ? (tk ? t : bpc + 4) : st ? m_pc : nxt;
    if (bv) begin
      if (m_bc < CMAX) m_bc++;
      if (mis && m_mc < CMAX) m_mc++;
      if (hit) m_ctr[ix] = tk ? (m_ctr[ix] < 3 ? m_ctr[ix] + 1 : 3) : (m_ctr[ix] > 0 ? m_ctr[ix] - 1 : 0);
      else if (tk) m_ctr[ix] = 2;
      if (tk) begin m_v[ix] = 1; m_tag[ix] = bpc >> 6; m_tgt[ix] = t; end
    end
    e.pc = m_pc; e.fl = mis; e.bc = m_bc; e.mc = m_mc; e.pt = m_pred(m_pc);
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  always @(negedge clk) begin
    if (rst_n && q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      vectors++;
      if (pc !== e.pc || flush !== e.fl || branch_cnt !== CW'(e.bc) ||
          mispred_cnt !== CW'(e.mc) || pred_taken !== e.pt) begin
        miscompares++;
        $display("FAIL cycle_state: got pc=%0h fl=%0b bc=%0d mc=%0d pt=%0b expected pc=%0h fl=%0b bc=%0d mc=%0d pt=%0b",
                 pc, flush, branch_cnt, mispred_cnt, pred_taken, e.pc, e.fl, e.bc, e.mc, e.pt);
      end
    end
  end

  initial begin
    logic [31:0] bpc, a, b, t;
    logic [2:0]  md;
    bit          bp;
    model_reset();
    #12;
    chk("reset_pc", pc, 0);
    chk("reset_flush", {31'b0, flush}, 0);
    chk("reset_bcnt", 32'(branch_cnt), 0);
    chk("reset_mcnt", 32'(mispred_cnt), 0);
    @(negedge clk); #1 rst_n = 1;

    idle(3);
    chk("seq_pc12", pc, 12);

    step(0, 1, 0, 3'd1, 5, 7, 12, 0);
    chk("bne_redirect_pc", pc, 12);
    chk("bne_flush", {31'b0, flush}, 1);
    chk("bne_mcnt", 32'(mispred_cnt), 1);
    chk("bne_bcnt", 32'(branch_cnt), 1);
    idle(1);
    chk("flush_one_cycle", {31'b0, flush}, 0);

    step(0, 1, 4, 3'd1, 7, 7, 60, 0);
    chk("bne_nt_flush", {31'b0, flush}, 0);
    chk("bne_nt_mcnt", 32'(mispred_cnt), 1);

    step(0, 1, 8, 3'd0, 3, 3, 40, 0);
    step(0, 1, 8, 3'd0, 3, 3, 40, 0);
    step(0, 1, 100, 3'd0, 1, 1, 8, 0);
    chk("btb_fetch_pc8", pc, 8);
    chk("btb_pred_taken", {31'b0, pred_taken}, 1);
    step(0, 1, 8, 3'd0, 9, 9, 40, 1);
    chk("btb_pred_next", pc, 40);
    chk("btb_correct_noflush", {31'b0, flush}, 0);

    step(0, 1, 300, 3'd2, 32'hFFFF_FFFF, 1, 500, 0);
    chk("blt_signed_taken", {31'b0, flush}, 1);
    step(0, 1, 304, 3'd4, 32'hFFFF_FFFF, 1, 500, 0);
    chk("bltu_not_taken", {31'b0, flush}, 0);
    step(0, 1, 308, 3'd7, 4, 4, 500, 0);
    chk("mode7_never", {31'b0, flush}, 0);

    step(1, 1, 200, 3'd6, 0, 0, 64, 0);
    chk("stall_redirect_pc", pc, 64);
    idle(1);

    step(0, 1, 72, 3'd6, 0, 0, 400, 0);
    chk("pre_reset_flush", {31'b0, flush}, 1);
    rst_n = 0;
    q.delete();
    model_reset();
    #1;
    chk("async_reset_pc", pc, 0);
    chk("async_reset_flush", {31'b0, flush}, 0);
    chk("async_reset_mcnt", 32'(mispred_cnt), 0);
    @(negedge clk); #1 rst_n = 1;

    for (int i = 0; i < 400; i++) begin
      bpc = {$urandom_range(0, 1) == 1 ? 26'd1 : 26'd0, 4'($urandom_range(0, 15)), 2'b00};
      md  = 3'($urandom_range(0, 7));
      a   = $urandom_range(0, 3) == 0 ? $urandom : 32'($urandom_range(0, 3)) - 32'd1;
      b   = $urandom_range(0, 1) == 0 ? a : 32'($urandom_range(0, 3)) - 32'd1;
      t   = {24'd0, 6'($urandom_range(0, 63)), 2'b00};
      bp  = $urandom_range(0, 1) == 1 ? m_pred(bpc) : 1'($urandom_range(0, 1));
      step($urandom_range(0, 3) == 0, $urandom_range(0, 9) < 6, bpc, md, a, b, t, bp);
    end
    chk("bcnt_saturated", 32'(branch_cnt), CMAX);

    for (int i = 0; i < CMAX + 6; i++) step(0, 1, 32'(i * 4), 3'd6, 0, 0, 128, 0);
    chk("mcnt_saturated", 32'(mispred_cnt), CMAX);
    chk("bcnt_no_wrap", 32'(branch_cnt), CMAX);

    @(negedge clk); #1;
    chk("scoreboard_drained", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
